mux_rr_arbiter: RTL and testbench
=================================

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, data width of each requester beat and of dout.
REQ-002 Parameter: TIMEOUT, 16, stall cycles before a locked grant is forcibly released; legal 0..255; 0 disables the timeout.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 req  input  4  per-requester request; bit k high means din_k holds a valid beat.
REQ-006 din0..din3  input  WIDTH each  requester beat data.
REQ-007 last  input  4  per-requester end-of-packet flag, qualified by req[k].
REQ-008 gnt  output  4  registered one-hot grant; all-zero when idle.
REQ-009 sel  output  2  registered index of the granted requester; drives a downstream 4:1 mux select.
REQ-010 take  output  4  combinational one-hot beat-accept pulse to the requesters.
REQ-011 dout  output  WIDTH  registered output beat.
REQ-012 dout_last  output  1  registered last flag of dout.
REQ-013 dout_valid  output  1  dout holds an undelivered beat.
REQ-014 dout_ready  input  1  downstream accepts dout this cycle when dout_valid is high.
REQ-015 busy  output  1  high in state LOCK.
REQ-016 timeout  output  1  one-cycle pulse when a grant is released by the timeout.

Function
REQ-017 Two states: IDLE and LOCK; ptr[1:0] is the round-robin start pointer.
REQ-018 IDLE: if req != 0, the winner is the first k with req[k]=1, searching ptr, ptr+1, ... mod 4; next edge sets gnt to one-hot(k), sel to k, and the state to LOCK.
REQ-019 IDLE with req == 0: no state change; gnt stays 0.
REQ-020 take[k] = busy & gnt[k] & req[k] & (~dout_valid | dout_ready); in IDLE take is 0.
REQ-021 On take[sel]: next edge loads dout with din_sel, dout_last with last[sel], and sets dout_valid to 1.
REQ-022 dout_valid clears on an edge where dout_valid & dout_ready is high and no take occurs.
REQ-023 Requesters hold din/last stable while req is high and take is low; dropping req mid-packet is legal and keeps the lock.
REQ-024 take with last[sel]=1: next edge sets state to IDLE, gnt to 0, and ptr to sel+1 (mod 4).
REQ-025 After a packet end, the state spends at least one IDLE cycle before re-arbitration (one bubble), even if requests are pending.
REQ-026 Latency: req high in IDLE at cycle n gives gnt at n+1, earliest take at n+1, and dout_valid at n+2.
REQ-027 Stall counter (8 bit): clears on entry to LOCK and on every take; otherwise increments each LOCK cycle and saturates at 255.
REQ-028 If TIMEOUT != 0 and the counter equals TIMEOUT-1 on a LOCK cycle without take: next edge sets state to IDLE, gnt to 0, ptr to sel+1, and pulses timeout for one cycle; dout contents are unaffected.
REQ-029 sel is unchanged on entry to IDLE.
REQ-030 gnt is never multi-hot; take is never asserted for any bit other than sel.

Reset
REQ-031 Assertion of rst_n low immediately sets: state IDLE, ptr 0, gnt 0, sel 0, dout 0, dout_last 0, dout_valid 0, timeout 0, counter 0; any in-flight beat is discarded.
REQ-032 Assertion of rst_n low forces take and busy to 0 combinationally.
REQ-033 The first arbitration after reset release uses ptr=0.

Verification
REQ-034 Fairness: req=4'b1111 held, every beat with last=1, dout_ready=1 -> grant order 0,1,2,3,0 with one IDLE bubble between grants.
REQ-035 Multi-beat packet: req[2] sends 3 beats A5,3C,F0 (last on F0) while req[0]=1 -> dout A5,3C,F0 with dout_last only on F0; gnt[0] comes after the bubble; ptr=3.
REQ-036 Backpressure: dout_valid=1 with dout_ready=0 for 5 cycles -> take=0 and dout holds its value; dout_ready=1 gives one take in that same cycle.
REQ-037 Timeout: TIMEOUT=4; requester 1 locked, then drops req without last -> timeout pulse after 4 stall cycles, gnt=0, next winner searched from 2.
REQ-038 Reset mid-packet: rst_n low for 1 cycle during LOCK with dout_valid=1 -> all outputs 0 within that cycle; after release, req=4'b1000 -> gnt=4'b1000 at the next edge.

Source files
------------

// File: rtl/mux_rr_arbiter_if.sv
// Bundle between four packet requesters, the round-robin arbiter and the
// downstream beat consumer.
interface mux_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [3:0]       req;
  logic [WIDTH-1:0] din0;
  logic [WIDTH-1:0] din1;
  logic [WIDTH-1:0] din2;
  logic [WIDTH-1:0] din3;
  logic [3:0]       last;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic [3:0]       take;
  logic [WIDTH-1:0] dout;
  logic             dout_last;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;
  logic             timeout;

  modport master (
    output req, din0, din1, din2, din3, last, dout_ready,
    input  gnt, sel, take, dout, dout_last, dout_valid, busy, timeout
  );

  modport slave (
    input  req, din0, din1, din2, din3, last, dout_ready,
    output gnt, sel, take, dout, dout_last, dout_valid, busy, timeout
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Four-way round-robin packet arbiter: locks onto one requester until its
// last beat (or a stall timeout) and forwards beats through a one-deep register.
module mux_rr_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_rr_arbiter_if.slave bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;
  localparam bit         TO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TO_LIM  = 8'(TIMEOUT - 1);

  logic [0:0]       state_r;
  logic [1:0]       ptr_r;
  logic [1:0]       sel_r;
  logic [3:0]       gnt_r;
  logic [7:0]       stall_cnt_r;
  logic [WIDTH-1:0] dout_r;
  logic             dout_last_r;
  logic             dout_valid_r;
  logic             timeout_r;

  logic [7:0]       req_dbl_s;
  logic [3:0]       rot_s;
  logic [1:0]       off_s;
  logic [1:0]       win_s;
  logic             busy_s;
  logic [3:0]       take_s;
  logic             take_any_s;
  logic [WIDTH-1:0] din_mux_s;
  logic             last_mux_s;
  logic             to_hit_s;

  // Round-robin winner: rotate requests so ptr sits at bit 0, then priority-encode.
  always_comb begin
    req_dbl_s = {bus.req, bus.req} >> ptr_r;
    rot_s     = req_dbl_s[3:0];
    if (rot_s[0]) begin
      off_s = 2'd0;
    end else if (rot_s[1]) begin
      off_s = 2'd1;
    end else if (rot_s[2]) begin
      off_s = 2'd2;
    end else begin
      off_s = 2'd3;
    end
    win_s = ptr_r + off_s;
  end

  // Beat accept and source select; gating with rst_n keeps take/busy low during reset.
  always_comb begin
    busy_s     = rst_n & (state_r == ST_LOCK);
    take_s     = 4'b0000;
    if (busy_s && (!dout_valid_r || bus.dout_ready)) begin
      take_s = gnt_r & bus.req;
    end else begin
      take_s = 4'b0000;
    end
    take_any_s = |take_s;
    case (sel_r)
      2'd0:    begin din_mux_s = bus.din0; last_mux_s = bus.last[0]; end
      2'd1:    begin din_mux_s = bus.din1; last_mux_s = bus.last[1]; end
      2'd2:    begin din_mux_s = bus.din2; last_mux_s = bus.last[2]; end
      2'd3:    begin din_mux_s = bus.din3; last_mux_s = bus.last[3]; end
      default: begin din_mux_s = bus.din0; last_mux_s = bus.last[0]; end
    endcase
    to_hit_s = TO_EN && busy_s && !take_any_s && (stall_cnt_r == TO_LIM);
  end

  // Arbitration FSM, grant/select registers, stall counter and timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      ptr_r       <= 2'd0;
      sel_r       <= 2'd0;
      gnt_r       <= 4'b0000;
      stall_cnt_r <= 8'd0;
      timeout_r   <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (|bus.req) begin
            state_r     <= ST_LOCK;
            gnt_r       <= 4'b0001 << win_s;
            sel_r       <= win_s;
            stall_cnt_r <= 8'd0;
          end
        end
        ST_LOCK: begin
          if (take_any_s && last_mux_s) begin
            state_r     <= ST_IDLE;
            gnt_r       <= 4'b0000;
            ptr_r       <= sel_r + 2'd1;
            stall_cnt_r <= 8'd0;
          end else if (to_hit_s) begin
            state_r     <= ST_IDLE;
            gnt_r       <= 4'b0000;
            ptr_r       <= sel_r + 2'd1;
            stall_cnt_r <= 8'd0;
            timeout_r   <= 1'b1;
          end else if (take_any_s) begin
            stall_cnt_r <= 8'd0;
          end else if (stall_cnt_r != 8'hFF) begin
            stall_cnt_r <= stall_cnt_r + 8'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          gnt_r   <= 4'b0000;
        end
      endcase
    end
  end

  // Output beat register: a take always wins over draining the held beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r       <= '0;
      dout_last_r  <= 1'b0;
      dout_valid_r <= 1'b0;
    end else if (take_any_s) begin
      dout_r       <= din_mux_s;
      dout_last_r  <= last_mux_s;
      dout_valid_r <= 1'b1;
    end else if (dout_valid_r && bus.dout_ready) begin
      dout_valid_r <= 1'b0;
    end
  end

  assign bus.gnt        = gnt_r;
  assign bus.sel        = sel_r;
  assign bus.take       = take_s;
  assign bus.dout       = dout_r;
  assign bus.dout_last  = dout_last_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.busy       = busy_s;
  assign bus.timeout    = timeout_r;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: dut_a (TIMEOUT=16) carries the main
// scenarios, dut_b (TIMEOUT=4) mirrors its inputs for the timeout scenario.
module tb_mux_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter_if #(.WIDTH(8)) bus_a ();
  mux_rr_arbiter_if #(.WIDTH(8)) bus_b ();

  assign bus_b.req        = bus_a.req;
  assign bus_b.din0       = bus_a.din0;
  assign bus_b.din1       = bus_a.din1;
  assign bus_b.din2       = bus_a.din2;
  assign bus_b.din3       = bus_a.din3;
  assign bus_b.last       = bus_a.last;
  assign bus_b.dout_ready = bus_a.dout_ready;

  mux_rr_arbiter #(.WIDTH(8), .TIMEOUT(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  mux_rr_arbiter #(.WIDTH(8), .TIMEOUT(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n            = 1'b0;
    bus_a.req        = 4'b0000;
    bus_a.din0       = 8'h00;
    bus_a.din1       = 8'h00;
    bus_a.din2       = 8'h00;
    bus_a.din3       = 8'h00;
    bus_a.last       = 4'b0000;
    bus_a.dout_ready = 1'b1;

    // reset state
    #2;
    check("rst_gnt",   32'(bus_a.gnt),        32'h0);
    check("rst_sel",   32'(bus_a.sel),        32'h0);
    check("rst_dout",  32'(bus_a.dout),       32'h0);
    check("rst_last",  32'(bus_a.dout_last),  32'h0);
    check("rst_valid", 32'(bus_a.dout_valid), 32'h0);
    check("rst_busy",  32'(bus_a.busy),       32'h0);
    check("rst_to",    32'(bus_a.timeout),    32'h0);
    check("rst_take",  32'(bus_a.take),       32'h0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    check("idle_gnt", 32'(bus_a.gnt), 32'h0);

    // fairness: all requesting, single-beat packets, grants 0,1,2,3,0
    bus_a.req  = 4'b1111;
    bus_a.last = 4'b1111;
    bus_a.din0 = 8'h10;
    bus_a.din1 = 8'h11;
    bus_a.din2 = 8'h12;
    bus_a.din3 = 8'h13;
    for (int k = 0; k < 5; k++) begin
      int w;
      w = k % 4;
      tick;
      check("fair_gnt",  32'(bus_a.gnt),  32'd1 << w);
      check("fair_sel",  32'(bus_a.sel),  32'(w));
      check("fair_busy", 32'(bus_a.busy), 32'h1);
      check("fair_take", 32'(bus_a.take), 32'd1 << w);
      tick;
      check("fair_bubble_gnt",  32'(bus_a.gnt),        32'h0);
      check("fair_bubble_busy", 32'(bus_a.busy),       32'h0);
      check("fair_bubble_take", 32'(bus_a.take),       32'h0);
      check("fair_dout",        32'(bus_a.dout),       32'h10 + 32'(w));
      check("fair_dlast",       32'(bus_a.dout_last),  32'h1);
      check("fair_valid",       32'(bus_a.dout_valid), 32'h1);
    end
    bus_a.req  = 4'b0000;
    bus_a.last = 4'b0000;
    tick;
    check("fair_drain", 32'(bus_a.dout_valid), 32'h0);

    // multi-beat packet from 2 while 0 also requests (ptr=1)
    bus_a.req  = 4'b0101;
    bus_a.din2 = 8'hA5;
    bus_a.din0 = 8'h77;
    tick;
    check("mb_gnt",  32'(bus_a.gnt),  32'h4);
    check("mb_sel",  32'(bus_a.sel),  32'h2);
    check("mb_take", 32'(bus_a.take), 32'h4);
    tick;
    check("mb_d0",     32'(bus_a.dout),       32'hA5);
    check("mb_l0",     32'(bus_a.dout_last),  32'h0);
    check("mb_v0",     32'(bus_a.dout_valid), 32'h1);
    check("mb_lock",   32'(bus_a.gnt),        32'h4);
    bus_a.din2 = 8'h3C;
    #1;
    check("mb_take1", 32'(bus_a.take), 32'h4);
    tick;
    check("mb_d1", 32'(bus_a.dout),      32'h3C);
    check("mb_l1", 32'(bus_a.dout_last), 32'h0);
    bus_a.din2 = 8'hF0;
    bus_a.last = 4'b0100;
    tick;
    check("mb_d2",   32'(bus_a.dout),      32'hF0);
    check("mb_l2",   32'(bus_a.dout_last), 32'h1);
    check("mb_rel",  32'(bus_a.gnt),       32'h0);
    check("mb_busy", 32'(bus_a.busy),      32'h0);
    bus_a.din2 = 8'h99;
    bus_a.last = 4'b0001;
    tick;
    check("mb_next_gnt",   32'(bus_a.gnt),        32'h1);
    check("mb_next_sel",   32'(bus_a.sel),        32'h0);
    check("mb_next_valid", 32'(bus_a.dout_valid), 32'h0);
    check("mb_next_take",  32'(bus_a.take),       32'h1);
    tick;
    check("mb_next_dout", 32'(bus_a.dout), 32'h77);
    check("mb_next_rel",  32'(bus_a.gnt),  32'h0);
    bus_a.req  = 4'b0000;
    bus_a.last = 4'b0000;
    tick;
    check("mb_drain", 32'(bus_a.dout_valid), 32'h0);

    // backpressure: 5 stalled cycles, then ready gives a same-cycle take
    bus_a.req  = 4'b0010;
    bus_a.din1 = 8'h5A;
    tick;
    check("bp_gnt",  32'(bus_a.gnt),  32'h2);
    check("bp_take", 32'(bus_a.take), 32'h2);
    tick;
    check("bp_d0", 32'(bus_a.dout),       32'h5A);
    check("bp_v0", 32'(bus_a.dout_valid), 32'h1);
    bus_a.din1       = 8'h6B;
    bus_a.dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_stall_take", 32'(bus_a.take),       32'h0);
      check("bp_stall_dout", 32'(bus_a.dout),       32'h5A);
      check("bp_stall_vld",  32'(bus_a.dout_valid), 32'h1);
      tick;
    end
    check("bp_still_lock", 32'(bus_a.gnt), 32'h2);
    bus_a.dout_ready = 1'b1;
    bus_a.last       = 4'b0010;
    #1;
    check("bp_resume_take", 32'(bus_a.take), 32'h2);
    tick;
    check("bp_d1",  32'(bus_a.dout),      32'h6B);
    check("bp_l1",  32'(bus_a.dout_last), 32'h1);
    check("bp_rel", 32'(bus_a.gnt),       32'h0);
    bus_a.req  = 4'b0000;
    bus_a.last = 4'b0000;
    tick;
    check("bp_drain", 32'(bus_a.dout_valid), 32'h0);

    // reset in the middle of a packet with a beat in flight
    bus_a.req  = 4'b0100;
    bus_a.din2 = 8'h11;
    tick;
    check("mr_gnt", 32'(bus_a.gnt), 32'h4);
    tick;
    check("mr_valid", 32'(bus_a.dout_valid), 32'h1);
    check("mr_busy",  32'(bus_a.busy),       32'h1);
    rst_n = 1'b0;
    #1;
    check("mr_gnt0",   32'(bus_a.gnt),        32'h0);
    check("mr_sel0",   32'(bus_a.sel),        32'h0);
    check("mr_dout0",  32'(bus_a.dout),       32'h0);
    check("mr_last0",  32'(bus_a.dout_last),  32'h0);
    check("mr_valid0", 32'(bus_a.dout_valid), 32'h0);
    check("mr_busy0",  32'(bus_a.busy),       32'h0);
    check("mr_take0",  32'(bus_a.take),       32'h0);
    check("mr_to0",    32'(bus_a.timeout),    32'h0);
    tick;
    rst_n      = 1'b1;
    bus_a.req  = 4'b1000;
    bus_a.din3 = 8'h22;
    bus_a.last = 4'b1000;
    tick;
    check("mr_post_gnt",  32'(bus_a.gnt),  32'h8);
    check("mr_post_sel",  32'(bus_a.sel),  32'h3);
    check("mr_post_take", 32'(bus_a.take), 32'h8);
    tick;
    check("mr_post_dout", 32'(bus_a.dout),      32'h22);
    check("mr_post_last", 32'(bus_a.dout_last), 32'h1);
    bus_a.req  = 4'b0000;
    bus_a.last = 4'b0000;
    tick;
    check("mr_drain", 32'(bus_a.dout_valid), 32'h0);

    // timeout on dut_b: requester 1 drops req mid-packet
    bus_a.req  = 4'b0010;
    bus_a.din1 = 8'h33;
    tick;
    check("to_gnt", 32'(bus_b.gnt), 32'h2);
    tick;
    check("to_dout", 32'(bus_b.dout), 32'h33);
    bus_a.req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("to_early_pulse", 32'(bus_b.timeout), 32'h0);
      check("to_early_busy",  32'(bus_b.busy),    32'h1);
    end
    tick;
    check("to_pulse",     32'(bus_b.timeout), 32'h1);
    check("to_gnt0",      32'(bus_b.gnt),     32'h0);
    check("to_busy0",     32'(bus_b.busy),    32'h0);
    check("to_dout_keep", 32'(bus_b.dout),    32'h33);
    check("to_a_locked",  32'(bus_a.busy),    32'h1);
    bus_a.req  = 4'b1011;
    bus_a.din3 = 8'h44;
    bus_a.last = 4'b1000;
    tick;
    check("to_pulse_end", 32'(bus_b.timeout), 32'h0);
    check("to_next_gnt",  32'(bus_b.gnt),     32'h8);
    check("to_next_sel",  32'(bus_b.sel),     32'h3);
    tick;
    check("to_next_dout", 32'(bus_b.dout), 32'h44);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
